// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Control side of the register-file/ALU datapath. Fetches 20-bit instructions
//   from a synchronous program memory (data valid one cycle after the address),
//   decodes them and drives the datapath register addresses, write strobe and
//   ALU controls. Each instruction takes two cycles: FETCH, then EXEC.
//
//   Instruction word: [19:16] op, [15:12] WA, [11:8] RA1, [7:0] imm.
//   Register forms take RA2 from imm[3:0].
//
// Ports
//   CLK, RESET      clock; synchronous active-high reset
//   start           1-cycle pulse, begins execution at PC 0 from IDLE/HALT
//   instr_addr      program memory address (current PC)
//   instr_data      program memory read data
//   Zero            datapath zero flag for the current ALU controls
//   RA1/RA2/WA      datapath register addresses
//   write_enable    datapath register write strobe
//   ALUSrc          1 selects immediate as the second ALU operand
//   ALUControl      00 AND, 01 OR, 10 ADD, 11 SUB
//   immediate       immediate operand / branch target
//   busy, halted    status (FETCH/EXEC, HALT)
//   illegal         1-cycle pulse when an undefined opcode executes
//
// Configuration
//   INSTR_SEQ_RETIRE_COUNT_EN : adds retired_count[15:0], a saturating count of
//   executed instructions, cleared by RESET and by an accepted start.
// -----------------------------------------------------------------------------
module instr_sequencer #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 20
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               start,
   output logic [PC_W-1:0]    instr_addr,
   input  logic [INSTR_W-1:0] instr_data,
   input  logic               Zero,
   output logic [3:0]         RA1,
   output logic [3:0]         RA2,
   output logic [3:0]         WA,
   output logic               write_enable,
   output logic               ALUSrc,
   output logic [1:0]         ALUControl,
   output logic [7:0]         immediate,
   output logic               busy,
   output logic               halted,
`ifdef INSTR_SEQ_RETIRE_COUNT_EN
   output logic               illegal,
   output logic [15:0]        retired_count
`else
   output logic               illegal
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            zero_flag_q, zero_flag_d;
   logic            we_s;
   logic            start_ok_s;

   logic [3:0] op_s, wa_s, ra1_s;
   logic [7:0] imm_s;

   assign op_s  = instr_data[19:16];
   assign wa_s  = instr_data[15:12];
   assign ra1_s = instr_data[11:8];
   assign imm_s = instr_data[7:0];

   assign instr_addr = pc_q;
   assign busy       = (state_q == S_FETCH) || (state_q == S_EXEC);
   assign halted     = (state_q == S_HALT);
   assign start_ok_s = start && ((state_q == S_IDLE) || (state_q == S_HALT));

   // Reset must be able to kill a write that is already decoded in EXEC.
   assign write_enable = we_s & ~RESET;

   // Next-state, PC, zero flag and datapath control decode.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      zero_flag_d = zero_flag_q;
      RA1         = 4'd0;
      RA2         = 4'd0;
      WA          = 4'd0;
      we_s        = 1'b0;
      ALUSrc      = 1'b0;
      ALUControl  = 2'b00;
      immediate   = 8'd0;
      illegal     = 1'b0;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start_ok_s) begin
               state_d = S_FETCH;
               pc_d    = '0;
            end else begin
               state_d = state_q;
            end
         end
         S_FETCH: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            case (op_s)
               4'h1, 4'h2, 4'h3, 4'h4: begin
                  WA          = wa_s;
                  RA1         = ra1_s;
                  RA2         = imm_s[3:0];
                  immediate   = imm_s;
                  ALUControl  = op_s[1:0] - 2'd1;   // (op-1)[1:0]
                  we_s        = 1'b1;
                  zero_flag_d = Zero;
               end
               4'h5, 4'h6, 4'h7, 4'h8: begin
                  WA          = wa_s;
                  RA1         = ra1_s;
                  immediate   = imm_s;
                  ALUSrc      = 1'b1;
                  ALUControl  = op_s[1:0] - 2'd1;
                  we_s        = 1'b1;
                  zero_flag_d = Zero;
               end
               4'h9: begin
                  immediate = imm_s;
                  if (zero_flag_q) begin
                     pc_d = PC_W'(imm_s);
                  end else begin
                     pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                  end
               end
               4'hA: begin
                  immediate = imm_s;
                  if (!zero_flag_q) begin
                     pc_d = PC_W'(imm_s);
                  end else begin
                     pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                  end
               end
               4'hB: begin
                  immediate = imm_s;
                  pc_d      = PC_W'(imm_s);
               end
               4'hF: begin
                  state_d = S_HALT;
                  pc_d    = pc_q;
               end
               4'hC, 4'hD, 4'hE: begin
                  // Undefined opcodes retire as NOP but are flagged.
                  illegal = 1'b1;
               end
               default: begin
                  // op 0: NOP
                  illegal = 1'b0;
               end
            endcase
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, PC and zero-flag registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         zero_flag_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         zero_flag_q <= zero_flag_d;
      end
   end

`ifdef INSTR_SEQ_RETIRE_COUNT_EN
   logic [15:0] retire_q, retire_d;

   assign retired_count = retire_q;

   // Saturating retire counter; an accepted start begins a fresh count.
   always_comb begin
      retire_d = retire_q;
      if (start_ok_s) begin
         retire_d = 16'd0;
      end else if ((state_q == S_EXEC) && (retire_q != 16'hFFFF)) begin
         retire_d = retire_q + 16'd1;
      end else begin
         retire_d = retire_q;
      end
   end

   // Retire counter register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         retire_q <= 16'd0;
      end else begin
         retire_q <= retire_d;
      end
   end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

   logic        CLK;
   logic        RESET;
   logic        start;
   logic [7:0]  instr_addr;
   logic [19:0] instr_data;
   logic        Zero;
   logic [3:0]  RA1, RA2, WA;
   logic        write_enable, ALUSrc;
   logic [1:0]  ALUControl;
   logic [7:0]  immediate;
   logic        busy, halted, illegal;
`ifdef INSTR_SEQ_RETIRE_COUNT_EN
   logic [15:0] retired_count;
`endif

   instr_sequencer dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .start        (start),
      .instr_addr   (instr_addr),
      .instr_data   (instr_data),
      .Zero         (Zero),
      .RA1          (RA1),
      .RA2          (RA2),
      .WA           (WA),
      .write_enable (write_enable),
      .ALUSrc       (ALUSrc),
      .ALUControl   (ALUControl),
      .immediate    (immediate),
      .busy         (busy),
      .halted       (halted),
`ifdef INSTR_SEQ_RETIRE_COUNT_EN
      .illegal      (illegal),
      .retired_count(retired_count)
`else
      .illegal      (illegal)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Program ROM (synchronous read) and register-file/ALU datapath model.
   logic [19:0] rom [256];
   logic [7:0]  regs [16];
   logic [7:0]  srca, srcb, alu_res;

   always @(posedge CLK) instr_data <= rom[instr_addr];

   always @(posedge CLK) begin
      if (RESET) begin
         for (int k = 0; k < 16; k++) regs[k] <= 8'd0;
      end else if (write_enable) begin
         regs[WA] <= alu_res;
      end
   end

   always_comb begin
      srca = regs[RA1];
      srcb = ALUSrc ? immediate : regs[RA2];
      case (ALUControl)
         2'b00:   alu_res = srca & srcb;
         2'b01:   alu_res = srca | srcb;
         2'b10:   alu_res = srca + srcb;
         default: alu_res = srca - srcb;
      endcase
      Zero = (alu_res == 8'd0);
   end

   // Scoreboard: {pc, WA, RA1, RA2, imm, ALUSrc, ALUControl, we, illegal}
   typedef logic [32:0] vec_t;
   vec_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(input logic [7:0] pc, input logic [3:0] wa, input logic [3:0] ra1,
                               input logic [3:0] ra2, input logic [7:0] imm, input logic src,
                               input logic [1:0] ctl, input logic we, input logic ill);
      return {pc, wa, ra1, ra2, imm, src, ctl, we, ill};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_rom();
      for (int a = 0; a < 256; a++) rom[a] = 20'h00000;
   endtask

   // FETCH cycle: PC must match next expected instruction, all controls idle.
   task automatic fetch_step();
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL fetch_sb observed=empty expected=entry");
      end else begin
         check("fetch_pc", 64'(instr_addr), 64'(exp_q[0][32:25]));
         check("fetch_ctl", 64'({busy, halted, write_enable, illegal, ALUSrc, ALUControl,
                                 WA, RA1, RA2, immediate}), 64'({1'b1, 26'd0}));
      end
   endtask

   // EXEC cycle: pop and compare the decoded controls.
   task automatic exec_step();
      vec_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL exec_sb observed=empty expected=entry");
      end else begin
         e = exp_q.pop_front();
         check("exec", 64'({instr_addr, WA, RA1, RA2, immediate, ALUSrc, ALUControl,
                            write_enable, illegal}), 64'(e));
      end
   endtask

   // Pulse start, then step through n instructions; optionally pulse start
   // again during the EXEC of instruction start_at (must be ignored).
   task automatic run(input int n, input int start_at);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         fetch_step();
         tick();
         exec_step();
         if (i == start_at) start = 1'b1;
         tick();
         start = 1'b0;
      end
      check("halted", 64'({halted, busy}), 64'({1'b1, 1'b0}));
   endtask

   task automatic load_prog1();
      clear_rom();
      rom[0] = 20'h71005;   // ADDI r1,r0,5
      rom[1] = 20'h72003;   // ADDI r2,r0,3
      rom[2] = 20'h43102;   // SUB  r3,r1,r2
      rom[3] = 20'hF0000;   // HALT
      exp_q.push_back(mk(8'h00, 4'd1, 4'd0, 4'd0, 8'h05, 1'b1, 2'b10, 1'b1, 1'b0));
      exp_q.push_back(mk(8'h01, 4'd2, 4'd0, 4'd0, 8'h03, 1'b1, 2'b10, 1'b1, 1'b0));
      exp_q.push_back(mk(8'h02, 4'd3, 4'd1, 4'd2, 8'h02, 1'b0, 2'b11, 1'b1, 1'b0));
      exp_q.push_back(mk(8'h03, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0));
   endtask

   initial begin
      RESET = 1'b1;
      start = 1'b0;
      clear_rom();
      tick();
      tick();
      check("reset_state", 64'({instr_addr, RA1, RA2, WA, write_enable, ALUSrc, ALUControl,
                                immediate, busy, halted, illegal}), 64'd0);

      // Reset wins over start.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("reset_over_start", 64'({busy, halted, instr_addr}), 64'd0);
      RESET = 1'b0;
      tick();

      // Test 1: straight-line ALU program.
      load_prog1();
      run(4, -1);
      check("r3_value", 64'(regs[3]), 64'd2);
`ifdef INSTR_SEQ_RETIRE_COUNT_EN
      check("retired_t1", 64'(retired_count), 64'd4);
`endif

      // Test 2: countdown loop with BNEZ, restarted from HALT.
      clear_rom();
      rom[0] = 20'h71003;   // ADDI r1,r0,3
      rom[1] = 20'h81101;   // SUBI r1,r1,1
      rom[2] = 20'hA0001;   // BNEZ 1
      rom[3] = 20'hF0000;   // HALT
      exp_q.push_back(mk(8'h00, 4'd1, 4'd0, 4'd0, 8'h03, 1'b1, 2'b10, 1'b1, 1'b0));
      for (int p = 0; p < 3; p++) begin
         exp_q.push_back(mk(8'h01, 4'd1, 4'd1, 4'd0, 8'h01, 1'b1, 2'b11, 1'b1, 1'b0));
         exp_q.push_back(mk(8'h02, 4'd0, 4'd0, 4'd0, 8'h01, 1'b0, 2'b00, 1'b0, 1'b0));
      end
      exp_q.push_back(mk(8'h03, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0));
      run(8, -1);
      check("r1_value", 64'(regs[1]), 64'd0);

      // Test 3: illegal opcode at address 4 behaves as NOP.
      clear_rom();
      rom[4] = 20'hC0000;
      rom[5] = 20'hF0000;
      for (int a = 0; a < 4; a++)
         exp_q.push_back(mk(8'(a), 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0));
      exp_q.push_back(mk(8'h04, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1));
      exp_q.push_back(mk(8'h05, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0));
      run(6, -1);

      // Test 4: JMP to 0xFF, NOP there wraps PC to 0.
      clear_rom();
      rom[0] = 20'hB00FF;   // JMP 0xFF
      exp_q.push_back(mk(8'h00, 4'd0, 4'd0, 4'd0, 8'hFF, 1'b0, 2'b00, 1'b0, 1'b0));
      exp_q.push_back(mk(8'hFF, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0));
      exp_q.push_back(mk(8'h00, 4'd6, 4'd1, 4'd2, 8'h02, 1'b0, 2'b10, 1'b1, 1'b0));
      start = 1'b1;
      tick();
      start = 1'b0;
      fetch_step();
      tick();
      exec_step();
      rom[0] = 20'h36102;   // second visit to PC 0 sees ADD r6,r1,r2
      tick();
      fetch_step();
      tick();
      exec_step();
      tick();
      fetch_step();         // wrapped fetch at 0x00
      tick();
      exec_step();          // ADD decoded with write_enable high

      // Test 5: reset asserted during the ADD's EXEC suppresses its write.
      RESET = 1'b1;
      #1;
      check("reset_we", 64'(write_enable), 64'd0);
      tick();
      check("post_reset", 64'({busy, halted, instr_addr}), 64'd0);
      RESET = 1'b0;
      tick();
      check("idle_hold", 64'({busy, halted, instr_addr}), 64'd0);

      // Test 6: start pulse mid-program is ignored.
      load_prog1();
      run(4, 1);
`ifdef INSTR_SEQ_RETIRE_COUNT_EN
      check("retired_t6", 64'(retired_count), 64'd4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
